// File: rtl/matrix_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_frame_reader
//  Description : Read-side engine of the LED-matrix frame double buffer.
//                For each byte address of the readable buffer half, it issues
//                one read strobe. It then captures one byte per channel and
//                shifts every channel's byte out MSB first on its own MOSI
//                line, using a shared SCK (mode 0) and a shared CS_n.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    I_clk          system clock, also the buffer read clock
//    I_rst_n        asynchronous active-low reset
//    I_data_valid   buffer holds a complete frame
//    I_frame_start  request one frame (only looked at while idle)
//    O_read_enable  one-cycle read strobe per byte address
//    O_adb_flat     read address replicated into every channel slice
//    I_dout_flat    read data, channel c in bits [c*8+7:c*8]
//    O_spi_sck      shared SPI clock, idle low
//    O_spi_cs_n     shared chip select, low for the whole frame
//    O_spi_mosi     per-channel serial data, MSB first
//    O_busy         frame in progress
//    O_frame_done   one-cycle pulse at end of frame
// ============================================================================
module matrix_frame_reader #(
  parameter int CHANNELS          = 12,
  parameter int BYTES_PER_CHANNEL = 2250,
  parameter int ADDR_W            = $clog2(BYTES_PER_CHANNEL),
  parameter int READ_LATENCY      = 2,
  parameter int CLK_DIV           = 4
) (
  input  logic                       I_clk,
  input  logic                       I_rst_n,
  input  logic                       I_data_valid,
  input  logic                       I_frame_start,
  output logic                       O_read_enable,
  output logic [CHANNELS*ADDR_W-1:0] O_adb_flat,
  input  logic [CHANNELS*8-1:0]      I_dout_flat,
  output logic                       O_spi_sck,
  output logic                       O_spi_cs_n,
  output logic [CHANNELS-1:0]        O_spi_mosi,
  output logic                       O_busy,
  output logic                       O_frame_done
);

  // Counter widths are kept at least one bit so that a divider or latency
  // of 1 still gives a legal (always-zero) counter.
  localparam int DIV_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] c_wait_init = WAIT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(BYTES_PER_CHANNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [WAIT_W-1:0]        r_wait;
  logic [DIV_W-1:0]         r_div;
  logic [2:0]               r_bit;
  logic [CHANNELS-1:0][7:0] r_shreg;
  logic                     r_sck;
  logic                     r_cs_n;
  logic [CHANNELS-1:0]      r_mosi;
  logic                     r_re;
  logic                     r_busy;
  logic                     r_done;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wait  <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_sck   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= '0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Strobes default low; the branches below raise them for one cycle.
      r_re   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          r_sck  <= 1'b0;
          r_cs_n <= 1'b1;
          r_mosi <= '0;
          r_busy <= 1'b0;
          if (I_frame_start && I_data_valid) begin
            r_state <= S_FETCH;
            r_re    <= 1'b1;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          // The strobe cycle is the first of the READ_LATENCY wait cycles.
          r_state <= S_WAIT;
          r_wait  <= c_wait_init;
        end

        S_WAIT: begin
          if (r_wait == '0) begin
            // Read data is valid now: capture every channel and present
            // bit 7 together with the first low SCK phase.
            r_shreg <= I_dout_flat;
            for (int c = 0; c < CHANNELS; c++) begin
              r_mosi[c] <= I_dout_flat[c*8+7];
            end
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_bit   <= 3'd7;
            r_sck   <= 1'b0;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end

        S_SHIFT: begin
          if (r_div == c_div_last) begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else if (r_bit != 3'd0) begin
              // End of a high phase: MOSI only moves here, at the start of
              // the next low phase, so it is settled at each rising edge.
              r_sck <= 1'b0;
              r_bit <= r_bit - 3'd1;
              for (int c = 0; c < CHANNELS; c++) begin
                r_mosi[c]  <= r_shreg[c][6];
                r_shreg[c] <= {r_shreg[c][6:0], 1'b0};
              end
            end else begin
              // Bit 0 is complete; CS_n remains low between bytes.
              r_sck  <= 1'b0;
              r_mosi <= '0;
              if (r_addr == c_addr_last) begin
                r_state <= S_DONE;
                r_cs_n  <= 1'b1;
                r_done  <= 1'b1;
              end else begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= S_FETCH;
                r_re    <= 1'b1;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign O_read_enable = r_re;
  assign O_adb_flat    = {CHANNELS{r_addr}};
  assign O_spi_sck     = r_sck;
  assign O_spi_cs_n    = r_cs_n;
  assign O_spi_mosi    = r_mosi;
  assign O_busy        = r_busy;
  assign O_frame_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_frame_reader
//  Description : Directed bench for matrix_frame_reader. Instance A has
//                2 channels, 3 bytes, READ_LATENCY=2, and CLK_DIV=2.
//                Instance B has 2 channels, 3 bytes, READ_LATENCY=1, and
//                CLK_DIV=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_frame_reader;

  localparam int CH = 2;
  localparam int NB = 3;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic             dv_a = 1'b0, st_a = 1'b0;
  logic             re_a, sck_a, cs_a, busy_a, done_a;
  logic [CH*AW-1:0] adb_a;
  logic [CH*8-1:0]  dout_a = '0, p1_a = '0;
  logic [CH-1:0]    mosi_a;

  // Instance B
  logic             dv_b = 1'b0, st_b = 1'b0;
  logic             re_b, sck_b, cs_b, busy_b, done_b;
  logic [CH*AW-1:0] adb_b;
  logic [CH*8-1:0]  dout_b = '0;
  logic [CH-1:0]    mosi_b;

  matrix_frame_reader #(.CHANNELS(CH), .BYTES_PER_CHANNEL(NB), .ADDR_W(AW),
                        .READ_LATENCY(2), .CLK_DIV(2)) u_dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_data_valid(dv_a), .I_frame_start(st_a),
    .O_read_enable(re_a), .O_adb_flat(adb_a), .I_dout_flat(dout_a),
    .O_spi_sck(sck_a), .O_spi_cs_n(cs_a), .O_spi_mosi(mosi_a),
    .O_busy(busy_a), .O_frame_done(done_a));

  matrix_frame_reader #(.CHANNELS(CH), .BYTES_PER_CHANNEL(NB), .ADDR_W(AW),
                        .READ_LATENCY(1), .CLK_DIV(1)) u_dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_data_valid(dv_b), .I_frame_start(st_b),
    .O_read_enable(re_b), .O_adb_flat(adb_b), .I_dout_flat(dout_b),
    .O_spi_sck(sck_b), .O_spi_cs_n(cs_b), .O_spi_mosi(mosi_b),
    .O_busy(busy_b), .O_frame_done(done_b));

  // Memory models: byte = addr + 0x10*channel, 0xEE when not strobed.
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      p1_a[c*8 +: 8]   <= re_a ? (8'(adb_a[c*AW +: AW]) + 8'(16*c)) : 8'hEE;
      dout_b[c*8 +: 8] <= re_b ? (8'(adb_b[c*AW +: AW]) + 8'(16*c)) : 8'hEE;
    end
    dout_a <= p1_a;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {re, sck, cs_n, busy, done, mosi[1:0], adb[3:0]}
  function automatic logic [10:0] pack_out(input logic re, input logic sck,
      input logic cs, input logic busy, input logic done,
      input logic [1:0] mosi, input logic [3:0] adb);
    return {re, sck, cs, busy, done, mosi, adb};
  endfunction

  typedef struct {
    int         cyc;
    logic       dv;
    logic       st;
    logic       re;
    logic       cs_n;
    logic       sck;
    logic       busy;
    logic       done;
    logic [1:0] adb;
  } vec_t;

  vec_t vt [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         re_cyc[$];
    int         done_cyc, rises, first_rise, last_rise, d2, bad_mosi, cs_bad;
    int         cnt_re, cnt_busy;
    logic       prev_sck;
    logic [1:0] prev_mosi;
    logic [23:0] cap0, cap1;

    //            cyc  dv    st    re    cs_n  sck   busy  done  adb
    vt[0]  = '{  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[1]  = '{  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[2]  = '{  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[3]  = '{  4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[4]  = '{  6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[5]  = '{  8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[6]  = '{ 20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[7]  = '{ 35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[8]  = '{ 36, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[9]  = '{ 37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[10] = '{ 50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    vt[11] = '{ 71, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[12] = '{ 90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[13] = '{105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
    vt[14] = '{106, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
    vt[15] = '{107, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[16] = '{108, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};

    // ---- reset held while inputs toggle
    #2 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dv_a = i[0]; st_a = i[1]; dv_b = i[1]; st_b = i[0];
      @(posedge clk); #1;
      check("reset_hold_a", 32'(pack_out(re_a, sck_a, cs_a, busy_a, done_a, mosi_a, adb_a)), 32'h100);
      check("reset_hold_b", 32'(pack_out(re_b, sck_b, cs_b, busy_b, done_b, mosi_b, adb_b)), 32'h100);
    end
    dv_a = 1'b0; st_a = 1'b0; dv_b = 1'b0; st_b = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // ---- start without valid data is ignored
    cnt_re = 0; cnt_busy = 0;
    st_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (re_a) cnt_re++;
      if (busy_a) cnt_busy++;
    end
    check("novalid_read_enable_count", cnt_re, 0);
    check("novalid_busy_count", cnt_busy, 0);

    // ---- full frame on A, driven by the vector table
    dv_a = 1'b1; st_a = 1'b1;
    @(posedge clk);  // accept edge = cycle 0
    prev_sck = 1'b0; cap0 = '0; cap1 = '0; rises = 0; done_cyc = 0;
    for (int c = 1; c <= 127; c++) begin
      #1;
      st_a = 1'b0;
      for (int i = 0; i < 17; i++) begin
        if (vt[i].cyc == c) begin
          dv_a = vt[i].dv;
          st_a = vt[i].st;
          check($sformatf("vec_cycle_%0d", c),
                32'({re_a, cs_a, sck_a, busy_a, done_a, adb_a[1:0], adb_a[3:2]}),
                32'({vt[i].re, vt[i].cs_n, vt[i].sck, vt[i].busy, vt[i].done,
                     vt[i].adb, vt[i].adb}));
        end
      end
      if (c <= 106) begin
        if (re_a) re_cyc.push_back(c);
        if (sck_a && !prev_sck) begin
          rises++;
          cap0 = {cap0[22:0], mosi_a[0]};
          cap1 = {cap1[22:0], mosi_a[1]};
        end
        if (done_a && done_cyc == 0) done_cyc = c;
      end
      prev_sck = sck_a;
      if (c < 127) @(posedge clk);
    end
    check("frame_read_enable_pulses", re_cyc.size(), 3);
    if (re_cyc.size() == 3) begin
      check("read_enable_cycle_0", re_cyc[0], 1);
      check("read_enable_cycle_1", re_cyc[1], 36);
      check("read_enable_cycle_2", re_cyc[2], 71);
    end
    check("sck_rise_count_a", rises, 24);
    check("mosi0_bytes", 32'(cap0), 32'h000102);
    check("mosi1_bytes", 32'(cap1), 32'h101112);
    check("frame_done_cycle", done_cyc, 106);

    // ---- asynchronous reset during SHIFT (second frame, its cycle 20)
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_cs_n", 32'(cs_a), 32'd1);
    check("async_rst_sck", 32'(sck_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_read_enable", 32'(re_a), 32'd0);
    dv_a = 1'b0; st_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // ---- SPI waveform with CLK_DIV=1, READ_LATENCY=1 on B
    #1 dv_b = 1'b1; st_b = 1'b1;
    @(posedge clk);
    prev_sck = 1'b0; prev_mosi = '0; cap0 = '0; cap1 = '0;
    rises = 0; first_rise = 0; last_rise = 0; d2 = 0; bad_mosi = 0;
    cs_bad = 0; done_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      st_b = 1'b0;
      if (sck_b && !prev_sck) begin
        rises++;
        if (first_rise == 0) first_rise = c;
        if (last_rise != 0 && c - last_rise == 2) d2++;
        last_rise = c;
        cap0 = {cap0[22:0], mosi_b[0]};
        cap1 = {cap1[22:0], mosi_b[1]};
      end
      if (sck_b && mosi_b != prev_mosi) bad_mosi++;
      if (c < 55 && cs_b) cs_bad++;
      if (done_b && done_cyc == 0) done_cyc = c;
      prev_sck = sck_b;
      prev_mosi = mosi_b;
      @(posedge clk);
    end
    check("b_first_sck_rise", first_rise, 4);
    check("b_sck_rise_count", rises, 24);
    check("b_two_cycle_periods", d2, 21);
    check("b_mosi_change_in_high", bad_mosi, 0);
    check("b_cs_n_high_mid_frame", cs_bad, 0);
    check("b_frame_done_cycle", done_cyc, 55);
    check("b_mosi0_bytes", 32'(cap0), 32'h000102);
    check("b_mosi1_bytes", 32'(cap1), 32'h101112);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
